// File: rtl/bcd2bin_arb_pkg.sv
// Shared definitions for the bcd2bin arbiter: FSM encoding, datapath widths
// and a helper for sizing requester indices.
package bcd2bin_arb_pkg;

    localparam int BCD_W = 4;
    localparam int BIN_W = 7;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic bcd_bad(input logic [BCD_W-1:0] d);
        return d > BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd2bin_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping around to index 0.
module bcd2bin_rr_pick
    import bcd2bin_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_vec,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any_vld
);

    int idx;

    // Scan from farthest to nearest so the nearest candidate overwrites last.
    always_comb begin
        gnt_idx = '0;
        any_vld = 1'b0;
        idx     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (req_vec[IDX_W'(idx)]) begin
                gnt_idx = IDX_W'(idx);
                any_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd2bin_arbiter.sv
// Round-robin front end sharing one bcd2bin engine among NUM_REQ requesters.
// Optional result self-check enabled by defining BCD2BIN_ARB_CHECK_EN.
module bcd2bin_arbiter
    import bcd2bin_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [BCD_W*NUM_REQ-1:0] req_bcd1,
    input  logic [BCD_W*NUM_REQ-1:0] req_bcd0,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [BIN_W-1:0]         rsp_bin,
    output logic                     rsp_err,
    output logic                     eng_start,
    output logic [BCD_W-1:0]         eng_bcd1,
    output logic [BCD_W-1:0]         eng_bcd0,
    input  logic                     eng_ready,
    input  logic                     eng_done_tick,
    input  logic [BIN_W-1:0]         eng_bin,
`ifdef BCD2BIN_ARB_CHECK_EN
    output logic [7:0]               chk_mismatch_cnt,
`endif
    output logic                     busy
);

    localparam int IDX_W = idx_w(NUM_REQ);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_REQ-1:0] ONE      = NUM_REQ'(1);

    logic [1:0]       state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] gnt;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             grant;
    logic [BCD_W-1:0] pick_bcd1;
    logic [BCD_W-1:0] pick_bcd0;
    logic [BCD_W-1:0] bcd1_q;
    logic [BCD_W-1:0] bcd0_q;
    logic [BIN_W-1:0] bin_q;
    logic             err_q;
    logic [TMO_W-1:0] tmo_cnt;
    logic             result_ok;

    bcd2bin_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_vec (req_valid),
        .ptr     (ptr),
        .gnt_idx (pick_idx),
        .any_vld (pick_any)
    );

    assign grant     = (state == ST_IDLE) && eng_ready && pick_any;
    assign pick_bcd1 = req_bcd1[BCD_W*pick_idx +: BCD_W];
    assign pick_bcd0 = req_bcd0[BCD_W*pick_idx +: BCD_W];

    // req_ready is combinational from IDLE, so it is masked while reset is held.
    assign req_ready = (grant && rst_n) ? (ONE << pick_idx) : '0;
    assign rsp_valid = (state == ST_RESP) ? (ONE << gnt) : '0;
    assign rsp_bin   = bin_q;
    assign rsp_err   = err_q;
    assign eng_start = (state == ST_ISSUE);
    assign eng_bcd1  = bcd1_q;
    assign eng_bcd0  = bcd0_q;
    assign busy      = (state != ST_IDLE);

`ifdef BCD2BIN_ARB_CHECK_EN
    logic [BIN_W-1:0] expect_bin;
    assign expect_bin = BIN_W'(bcd1_q) * BIN_W'(10) + BIN_W'(bcd0_q);
    assign result_ok  = (eng_bin == expect_bin);
`else
    assign result_ok  = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            gnt     <= '0;
            bcd1_q  <= '0;
            bcd0_q  <= '0;
            bin_q   <= '0;
            err_q   <= 1'b0;
            tmo_cnt <= '0;
`ifdef BCD2BIN_ARB_CHECK_EN
            chk_mismatch_cnt <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        gnt    <= pick_idx;
                        bcd1_q <= pick_bcd1;
                        bcd0_q <= pick_bcd0;
                        ptr    <= (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + 1'b1;
                        if (bcd_bad(pick_bcd1) || bcd_bad(pick_bcd0)) begin
                            bin_q <= '0;
                            err_q <= 1'b1;
                            state <= ST_RESP;
                        end else begin
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    tmo_cnt <= '0;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A done_tick coinciding with the last timeout cycle still counts as a result.
                    if (eng_done_tick) begin
                        bin_q <= eng_bin;
                        err_q <= !result_ok;
                        state <= ST_RESP;
`ifdef BCD2BIN_ARB_CHECK_EN
                        if (!result_ok && chk_mismatch_cnt != 8'hFF)
                            chk_mismatch_cnt <= chk_mismatch_cnt + 8'd1;
`endif
                    end else if (tmo_cnt == TMO_LAST) begin
                        bin_q <= '0;
                        err_q <= 1'b1;
                        state <= ST_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: begin
                    if (rsp_ready[gnt])
                        state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd2bin_arbiter.sv
// Directed bench for bcd2bin_arbiter with a small behavioural engine model.
module tb_bcd2bin_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_bcd1;
    logic [15:0] req_bcd0;
    logic [3:0]  rsp_valid;
    logic [3:0]  rsp_ready;
    logic [6:0]  rsp_bin;
    logic        rsp_err;
    logic        eng_start;
    logic [3:0]  eng_bcd1;
    logic [3:0]  eng_bcd0;
    logic        eng_ready;
    logic        eng_done_tick = 1'b0;
    logic [6:0]  eng_bin = '0;
    logic        busy;
`ifdef BCD2BIN_ARB_CHECK_EN
    logic [7:0]  chk_mismatch_cnt;
`endif

    int npass = 0;
    int ntot  = 0;
    int starts = 0;

    bit   eng_hang = 1'b0;
    bit   eng_run  = 1'b0;
    int   eng_cnt  = 0;
    logic [6:0] eng_acc = '0;

    always #5 clk = ~clk;

    bcd2bin_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(64)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_bcd1      (req_bcd1),
        .req_bcd0      (req_bcd0),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_bin       (rsp_bin),
        .rsp_err       (rsp_err),
        .eng_start     (eng_start),
        .eng_bcd1      (eng_bcd1),
        .eng_bcd0      (eng_bcd0),
        .eng_ready     (eng_ready),
        .eng_done_tick (eng_done_tick),
        .eng_bin       (eng_bin),
`ifdef BCD2BIN_ARB_CHECK_EN
        .chk_mismatch_cnt (chk_mismatch_cnt),
`endif
        .busy          (busy)
    );

    // Engine model: fixed 3-cycle latency, or never answers while eng_hang is set.
    always @(posedge clk) begin
        eng_done_tick <= 1'b0;
        if (eng_start) begin
            starts  <= starts + 1;
            eng_cnt <= 3;
            eng_acc <= 7'(eng_bcd1) * 7'd10 + 7'(eng_bcd0);
            eng_run <= !eng_hang;
        end else if (eng_run) begin
            if (eng_cnt <= 1) begin
                eng_done_tick <= 1'b1;
                eng_bin       <= eng_acc;
                eng_run       <= 1'b0;
            end else begin
                eng_cnt <= eng_cnt - 1;
            end
        end
    end

    task automatic set_req(input int i, input bit v, input logic [3:0] b1, input logic [3:0] b0);
        req_valid[i]      = v;
        req_bcd1[4*i +: 4] = b1;
        req_bcd0[4*i +: 4] = b0;
    endtask

    task automatic wait_rsp(input int limit, output int n);
        n = 0;
        while (rsp_valid == 4'b0000 && n < limit) begin
            @(negedge clk); #1;
            n++;
        end
    endtask

    task automatic wait_grant(input int limit, output int n);
        n = 0;
        while (req_ready == 4'b0000 && n < limit) begin
            @(negedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req_valid = 4'b0001;
        @(negedge clk); @(negedge clk); #1;
        ntot++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else npass++;
        ntot++; if (rsp_valid !== 4'b0000) $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); else npass++;
        ntot++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b want 0000", req_ready); else npass++;
        ntot++; if (eng_start !== 1'b0 || rsp_err !== 1'b0 || rsp_bin !== 7'd0 || eng_bcd1 !== 4'd0)
            $display("FAIL reset_outs: start=%b err=%b bin=%0d bcd1=%0d want all 0", eng_start, rsp_err, rsp_bin, eng_bcd1);
        else npass++;
        req_valid = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        int n;
        @(negedge clk);
        set_req(0, 1'b1, 4'd4, 4'd2); #1;
        ntot++; if (req_ready !== 4'b0001) $display("FAIL single_grant: got %b want 0001", req_ready); else npass++;
        @(negedge clk);
        set_req(0, 1'b0, 4'd0, 4'd0); #1;
        ntot++; if (eng_start !== 1'b1 || eng_bcd1 !== 4'd4 || eng_bcd0 !== 4'd2)
            $display("FAIL single_issue: start=%b bcd=%0d/%0d want 1 4/2", eng_start, eng_bcd1, eng_bcd0);
        else npass++;
        @(negedge clk); #1;
        ntot++; if (eng_start !== 1'b0 || eng_bcd1 !== 4'd4) $display("FAIL single_start_pulse: start=%b bcd1=%0d want 0 4", eng_start, eng_bcd1); else npass++;
        wait_rsp(50, n);
        ntot++; if (n >= 50 || rsp_valid !== 4'b0001 || rsp_bin !== 7'd42 || rsp_err !== 1'b0)
            $display("FAIL single_rsp: valid=%b bin=%0d err=%b want 0001 42 0", rsp_valid, rsp_bin, rsp_err);
        else npass++;
        @(negedge clk); #1;
        ntot++; if (busy !== 1'b0 || rsp_valid !== 4'b0000) $display("FAIL single_idle: busy=%b valid=%b want 0 0000", busy, rsp_valid); else npass++;
    endtask

    task automatic test_contention;
        int n;
        int g_exp[5]   = '{0, 1, 2, 3, 0};
        int bin_exp[5] = '{10, 25, 99, 0, 10};
        logic [3:0] oh;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        set_req(0, 1'b1, 4'd1, 4'd0);
        set_req(1, 1'b1, 4'd2, 4'd5);
        set_req(2, 1'b1, 4'd9, 4'd9);
        set_req(3, 1'b1, 4'd0, 4'd0);
        #1;
        for (int i = 0; i < 5; i++) begin
            oh = 4'b0001 << g_exp[i];
            wait_grant(20, n);
            ntot++; if (n >= 20 || req_ready !== oh) $display("FAIL contention_grant%0d: got %b want %b", i, req_ready, oh); else npass++;
            if (i == 4) begin
                @(negedge clk);
                req_valid = 4'b0000; #1;
            end
            wait_rsp(50, n);
            ntot++; if (n >= 50 || rsp_valid !== oh || rsp_bin !== 7'(bin_exp[i]) || rsp_err !== 1'b0)
                $display("FAIL contention_rsp%0d: valid=%b bin=%0d err=%b want %b %0d 0", i, rsp_valid, rsp_bin, rsp_err, oh, bin_exp[i]);
            else npass++;
        end
        @(negedge clk); #1;
    endtask

    task automatic test_bad_bcd;
        int s0;
        s0 = starts;
        @(negedge clk);
        set_req(2, 1'b1, 4'd10, 4'd3); #1;
        ntot++; if (req_ready !== 4'b0100) $display("FAIL bad_grant: got %b want 0100", req_ready); else npass++;
        @(negedge clk);
        set_req(2, 1'b0, 4'd0, 4'd0); #1;
        ntot++; if (rsp_valid !== 4'b0100 || rsp_err !== 1'b1 || rsp_bin !== 7'd0)
            $display("FAIL bad_tens_rsp: valid=%b err=%b bin=%0d want 0100 1 0", rsp_valid, rsp_err, rsp_bin);
        else npass++;
        @(negedge clk); #1;
        ntot++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) $display("FAIL bad_done: valid=%b busy=%b want 0000 0", rsp_valid, busy); else npass++;
        set_req(1, 1'b1, 4'd3, 4'd15); #1;
        ntot++; if (req_ready !== 4'b0010) $display("FAIL bad_units_grant: got %b want 0010", req_ready); else npass++;
        @(negedge clk);
        set_req(1, 1'b0, 4'd0, 4'd0); #1;
        ntot++; if (rsp_valid !== 4'b0010 || rsp_err !== 1'b1 || rsp_bin !== 7'd0)
            $display("FAIL bad_units_rsp: valid=%b err=%b bin=%0d want 0010 1 0", rsp_valid, rsp_err, rsp_bin);
        else npass++;
        @(negedge clk); #1;
        ntot++; if (starts !== s0) $display("FAIL bad_no_start: got %0d starts want %0d", starts, s0); else npass++;
    endtask

    task automatic test_timeout;
        int n;
        eng_hang = 1'b1;
        @(negedge clk);
        set_req(3, 1'b1, 4'd5, 4'd5); #1;
        ntot++; if (req_ready !== 4'b1000) $display("FAIL timeout_grant: got %b want 1000", req_ready); else npass++;
        @(negedge clk);
        set_req(3, 1'b0, 4'd0, 4'd0); #1;
        wait_rsp(200, n);
        ntot++; if (n !== 65) $display("FAIL timeout_latency: got %0d want 65", n); else npass++;
        ntot++; if (rsp_valid !== 4'b1000 || rsp_err !== 1'b1 || rsp_bin !== 7'd0)
            $display("FAIL timeout_rsp: valid=%b err=%b bin=%0d want 1000 1 0", rsp_valid, rsp_err, rsp_bin);
        else npass++;
        eng_ready = 1'b0;
        eng_hang  = 1'b0;
        set_req(0, 1'b1, 4'd3, 4'd4);
        repeat (5) @(negedge clk);
        #1;
        ntot++; if (req_ready !== 4'b0000 || busy !== 1'b0) $display("FAIL timeout_defer: ready=%b busy=%b want 0000 0", req_ready, busy); else npass++;
        eng_ready = 1'b1; #1;
        ntot++; if (req_ready !== 4'b0001) $display("FAIL timeout_regrant: got %b want 0001", req_ready); else npass++;
        @(negedge clk);
        set_req(0, 1'b0, 4'd0, 4'd0); #1;
        wait_rsp(50, n);
        ntot++; if (n >= 50 || rsp_bin !== 7'd34 || rsp_err !== 1'b0) $display("FAIL timeout_after: bin=%0d err=%b want 34 0", rsp_bin, rsp_err); else npass++;
        @(negedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int n;
        rsp_ready = 4'b0000;
        set_req(1, 1'b1, 4'd7, 4'd3);
        set_req(2, 1'b1, 4'd1, 4'd1); #1;
        ntot++; if (req_ready !== 4'b0010) $display("FAIL bp_grant: got %b want 0010", req_ready); else npass++;
        @(negedge clk);
        set_req(1, 1'b0, 4'd0, 4'd0); #1;
        wait_rsp(50, n);
        ntot++; if (n >= 50 || rsp_valid !== 4'b0010 || rsp_bin !== 7'd73) $display("FAIL bp_rsp: valid=%b bin=%0d want 0010 73", rsp_valid, rsp_bin); else npass++;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            ntot++;
            if (rsp_valid !== 4'b0010 || rsp_bin !== 7'd73 || rsp_err !== 1'b0 || req_ready !== 4'b0000 || eng_start !== 1'b0)
                $display("FAIL bp_hold%0d: valid=%b bin=%0d err=%b ready=%b start=%b want 0010 73 0 0000 0",
                         c, rsp_valid, rsp_bin, rsp_err, req_ready, eng_start);
            else npass++;
        end
        rsp_ready = 4'b0010;
        @(negedge clk); #1;
        ntot++; if (rsp_valid !== 4'b0000 || req_ready !== 4'b0100) $display("FAIL bp_release: valid=%b ready=%b want 0000 0100", rsp_valid, req_ready); else npass++;
        rsp_ready = 4'b1111;
        @(negedge clk);
        set_req(2, 1'b0, 4'd0, 4'd0); #1;
        wait_rsp(50, n);
        ntot++; if (n >= 50 || rsp_valid !== 4'b0100 || rsp_bin !== 7'd11) $display("FAIL bp_next: valid=%b bin=%0d want 0100 11", rsp_valid, rsp_bin); else npass++;
        @(negedge clk); #1;
    endtask

    task automatic test_reset_midflight;
        int n;
        eng_hang = 1'b1;
        set_req(1, 1'b1, 4'd2, 4'd2); #1;
        ntot++; if (req_ready !== 4'b0010) $display("FAIL mid_grant: got %b want 0010", req_ready); else npass++;
        @(negedge clk);
        set_req(1, 1'b0, 4'd0, 4'd0);
        repeat (4) @(negedge clk);
        #1;
        ntot++; if (busy !== 1'b1) $display("FAIL mid_busy: got %b want 1", busy); else npass++;
        rst_n = 1'b0;
        set_req(0, 1'b1, 4'd6, 4'd1);
        set_req(3, 1'b1, 4'd8, 4'd8);
        #1;
        ntot++; if (busy !== 1'b0 || rsp_valid !== 4'b0000 || eng_start !== 1'b0 || req_ready !== 4'b0000 || rsp_err !== 1'b0)
            $display("FAIL mid_reset_outs: busy=%b valid=%b start=%b ready=%b err=%b want all 0", busy, rsp_valid, eng_start, req_ready, rsp_err);
        else npass++;
        eng_hang = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; #1;
        ntot++; if (req_ready !== 4'b0001) $display("FAIL mid_first_grant: got %b want 0001", req_ready); else npass++;
        @(negedge clk);
        req_valid = 4'b0000; #1;
        wait_rsp(50, n);
        ntot++; if (n >= 50 || rsp_valid !== 4'b0001 || rsp_bin !== 7'd61) $display("FAIL mid_after: valid=%b bin=%0d want 0001 61", rsp_valid, rsp_bin); else npass++;
        @(negedge clk); #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_bcd1  = '0;
        req_bcd0  = '0;
        rsp_ready = 4'b1111;
        eng_ready = 1'b1;
        test_reset;
        test_single;
        test_contention;
        test_bad_bcd;
        test_timeout;
        test_back_to_back;
        test_reset_midflight;
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/bcd2bin_arbiter.md
Name: bcd2bin_arbiter

Overview:
- Shares one bcd2bin conversion engine among NUM_REQ requesters.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- The block arbitrates round-robin, issues a one-cycle start pulse to the engine and captures bin on done_tick. It routes the result back to the owning requester and flags malformed BCD input and engine timeouts.
- Sits between PRGA-mapped user logic (or bench stimulus) and the bcd2bin datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 64, maximum cycles in WAIT before aborting (at least 16).

Ports:
- clk  input  1  single clock for all logic.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  request valid per requester.
- req_ready  output  NUM_REQ  request accepted, asserted for 1 cycle to the granted requester only.
- req_bcd1  input  4*NUM_REQ  tens digit; slice i belongs to requester i.
- req_bcd0  input  4*NUM_REQ  units digit; slice i belongs to requester i.
- rsp_valid  output  NUM_REQ  response valid, one-hot, to the owner.
- rsp_ready  input  NUM_REQ  response consumed.
- rsp_bin  output  7  binary result, shared bus, meaningful only when rsp_valid is nonzero.
- rsp_err  output  1  response is an error (bad BCD or timeout).
- eng_start  output  1  start pulse to the engine.
- eng_bcd1  output  4  tens digit to the engine.
- eng_bcd0  output  4  units digit to the engine.
- eng_ready  input  1  engine idle.
- eng_done_tick  input  1  engine result valid (1 cycle).
- eng_bin  input  7  engine result.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset: all outputs 0; FSM = IDLE; round-robin pointer = 0; captured operands and result = 0.

States:
- IDLE
  - If any req_valid is set and eng_ready=1, grant the first set bit searching from the pointer upward with wrap.
  - In that same cycle: req_ready[g]=1; latch g, bcd1 and bcd0; set pointer = (g+1) mod NUM_REQ.
  - If either latched digit > 9, go to RESP with err=1, bin=0. The engine is not used.
  - Otherwise go to ISSUE.
  - If no request is valid, or eng_ready=0, stay in IDLE and do not grant.
- ISSUE: eng_start=1 for exactly 1 cycle; eng_bcd1/eng_bcd0 driven from the latch (the latch holds them for the whole transaction); go to WAIT and clear the timeout counter.
- WAIT
  - On eng_done_tick: capture eng_bin, err=0, go to RESP.
  - When the counter reaches TIMEOUT_CYCLES-1 with no done_tick: err=1, bin=0, go to RESP.
  - A done_tick in the same cycle as the timeout wins (valid result).
- RESP: rsp_valid[g]=1 with rsp_bin/rsp_err stable until rsp_ready[g]=1; in that cycle go to IDLE. Responses are never dropped.

Timing and boundary rules:
- Latency from request acceptance to rsp_valid: 2 + engine latency cycles. For a bad-BCD request, rsp_valid is asserted the cycle after acceptance.
- Only one transaction is outstanding. Other requesters see req_ready=0 until the FSM returns to IDLE.
- After a timeout, the next grant waits for eng_ready=1. A stale done_tick outside WAIT is ignored.
- Requesters must hold req_valid and their operands until req_ready. Dropping req_valid before grant is legal and loses nothing.
- Asserting rst_n low mid-transaction aborts it immediately with no response; the pointer returns to 0.
- bcd 9,9 converts to 99, the maximum, which fits 7 bits. Digits 10..15 are errors.

Optional Feature:
- Macro: BCD2BIN_ARB_CHECK_EN.
- When defined:
  - On done_tick, eng_bin is compared with 10*bcd1+bcd0, computed in 7 bits from the latched digits.
  - A mismatch forces rsp_err=1 while rsp_bin still carries eng_bin.
  - It also increments an extra output, chk_mismatch_cnt (8 bits), which saturates at 255 and resets to 0.
- When undefined: no comparator and no port; rsp_err reflects only bad BCD or timeout.

Decomposition:
- Package bcd2bin_arb_pkg: FSM state encoding (IDLE, ISSUE, WAIT, RESP), BCD_W=4, BIN_W=7, BCD_MAX=9, and a function for the index width of NUM_REQ.
- Sub-module bcd2bin_rr_pick: combinational round-robin picker.
  - Inputs: request vector and pointer.
  - Outputs: grant index and any-valid.
  - Instantiated once.

Test Plan:
- Single request: requester 0 sends 4,2 → req_ready[0] pulses; eng_start is 1 cycle later with eng_bcd 4/2; after the engine done_tick, rsp_valid[0]=1, rsp_bin=42, rsp_err=0.
- Contention: all 4 valid from reset → grant order 0,1,2,3,0; each rsp_bin correct (operands 1,0 / 2,5 / 9,9 / 0,0 → 10, 25, 99, 0).
- Bad BCD: requester 2 sends 10,3 → rsp_err=1, rsp_bin=0; eng_start never pulses.
- Timeout: engine holds done_tick low → rsp_err=1 after TIMEOUT_CYCLES in WAIT; next grant is deferred until eng_ready=1.
- Backpressure and reset:
  - With rsp_ready low for 20 cycles, rsp_valid, rsp_bin and rsp_err stay stable and no new grant occurs.
  - rst_n asserted in WAIT clears all outputs immediately, and the first grant after reset goes to requester 0.
